nest_block_checker: RTL and testbench

- Streaming ASCII tokenizer that tracks "begin"/"end" keyword nesting in a character stream, one character per accepted beat.
- Second-generation block-balance checker. Adds parametrised depth width and case mode, a valid qualifier, multiple delimiters, soft clear, a live depth output, and distinct sticky underflow/overflow errors.
- Sits behind the text/UART front end. Its status is read combinationally from registers.

---
 rtl/nest_block_checker.sv | 138 +++++++++++++
 tb/tb_nest_block_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/nest_block_checker.sv
// Streaming "begin"/"end" nesting checker: one ASCII character per valid beat,
// tentative depth update on the last keyword letter, committed by a delimiter.
module nest_block_checker #(
  parameter int DEPTH_W  = 16,
  parameter int CASE_INS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_under,
  output logic               err_over
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_B1, ST_B2, ST_B3, ST_B4, ST_BDN,
    ST_E1, ST_E2, ST_EDN, ST_SKIP, ST_LOCK
  } state_t;

  localparam logic [DEPTH_W-1:0] MAX_DEPTH = '1;
  localparam logic [DEPTH_W-1:0] ONE       = DEPTH_W'(1);

  state_t             r_state, w_state_nx;
  logic [DEPTH_W-1:0] r_depth, w_depth_nx;
  logic               r_pend_under, w_pend_under_nx;
  logic               r_pend_over, w_pend_over_nx;
  logic               r_err_under, w_err_under_nx;
  logic               r_err_over, w_err_over_nx;
  logic               w_dlm;

  function automatic logic f_is(input logic [7:0] c, input logic [7:0] lc);
    if (CASE_INS != 0) f_is = ((c | 8'h20) == lc);
    else               f_is = (c == lc);
  endfunction

  assign w_dlm = (in == 8'h20) || (in == 8'h09) || (in == 8'h0A) || (in == 8'h0D);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_state      <= ST_IDLE;
      r_depth      <= '0;
      r_pend_under <= 1'b0;
      r_pend_over  <= 1'b0;
      r_err_under  <= 1'b0;
      r_err_over   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_depth      <= w_depth_nx;
      r_pend_under <= w_pend_under_nx;
      r_pend_over  <= w_pend_over_nx;
      r_err_under  <= w_err_under_nx;
      r_err_over   <= w_err_over_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_depth_nx      = r_depth;
    w_pend_under_nx = r_pend_under;
    w_pend_over_nx  = r_pend_over;
    w_err_under_nx  = r_err_under;
    w_err_over_nx   = r_err_over;
    if (in_valid && (r_state != ST_LOCK)) begin
      case (r_state)
        ST_IDLE: begin
          if (f_is(in, "b"))      w_state_nx = ST_B1;
          else if (f_is(in, "e")) w_state_nx = ST_E1;
          else if (w_dlm)         w_state_nx = ST_IDLE;
          else                    w_state_nx = ST_SKIP;
        end
        ST_B1: w_state_nx = f_is(in, "e") ? ST_B2 : (w_dlm ? ST_IDLE : ST_SKIP);
        ST_B2: w_state_nx = f_is(in, "g") ? ST_B3 : (w_dlm ? ST_IDLE : ST_SKIP);
        ST_B3: w_state_nx = f_is(in, "i") ? ST_B4 : (w_dlm ? ST_IDLE : ST_SKIP);
        ST_E1: w_state_nx = f_is(in, "n") ? ST_E2 : (w_dlm ? ST_IDLE : ST_SKIP);
        ST_B4: begin
          if (f_is(in, "n")) begin
            w_state_nx = ST_BDN;
            // At the ceiling the depth saturates and the overflow is held pending.
            if (r_depth == MAX_DEPTH) w_pend_over_nx = 1'b1;
            else                      w_depth_nx     = r_depth + ONE;
          end else begin
            w_state_nx = w_dlm ? ST_IDLE : ST_SKIP;
          end
        end
        ST_E2: begin
          if (f_is(in, "d")) begin
            w_state_nx = ST_EDN;
            if (r_depth == '0) w_pend_under_nx = 1'b1;
            else               w_depth_nx      = r_depth - ONE;
          end else begin
            w_state_nx = w_dlm ? ST_IDLE : ST_SKIP;
          end
        end
        ST_BDN: begin
          if (w_dlm) begin
            if (r_pend_over) begin
              w_err_over_nx  = 1'b1;
              w_pend_over_nx = 1'b0;
              w_state_nx     = ST_LOCK;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            if (r_pend_over) w_pend_over_nx = 1'b0;
            else             w_depth_nx     = r_depth - ONE;
            w_state_nx = ST_SKIP;
          end
        end
        ST_EDN: begin
          if (w_dlm) begin
            if (r_pend_under) begin
              w_err_under_nx  = 1'b1;
              w_pend_under_nx = 1'b0;
              w_state_nx      = ST_LOCK;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end else begin
            if (r_pend_under) w_pend_under_nx = 1'b0;
            else              w_depth_nx      = r_depth + ONE;
            w_state_nx = ST_SKIP;
          end
        end
        ST_SKIP: if (w_dlm) w_state_nx = ST_IDLE;
        default: w_state_nx = r_state;
      endcase
    end
  end

  assign depth     = r_depth;
  assign err_under = r_err_under;
  assign err_over  = r_err_over;
  assign result    = (r_depth == '0) && !r_pend_under && !r_err_under && !r_err_over;

endmodule

// File: tb/tb_nest_block_checker.sv
// Directed bench for nest_block_checker: three parameterisations, scoreboard
// of expected outputs queued at drive time and checked one beat later.
module tb_nest_block_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        clr_a [3];
  logic        vld_a [3];
  logic [7:0]  in_a  [3];
  logic        res_a [3];
  logic        eu_a  [3];
  logic        eo_a  [3];
  logic [15:0] dep0;
  logic [1:0]  dep1;
  logic [15:0] dep2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    dut;
    int    dep;
    logic  res;
    logic  eu;
    logic  eo;
    string tag;
  } exp_t;

  exp_t sb[$];

  nest_block_checker #(.DEPTH_W(16), .CASE_INS(1)) u0 (
    .clk(clk), .reset(reset), .clr(clr_a[0]), .in_valid(vld_a[0]), .in(in_a[0]),
    .result(res_a[0]), .depth(dep0), .err_under(eu_a[0]), .err_over(eo_a[0]));

  nest_block_checker #(.DEPTH_W(2), .CASE_INS(1)) u1 (
    .clk(clk), .reset(reset), .clr(clr_a[1]), .in_valid(vld_a[1]), .in(in_a[1]),
    .result(res_a[1]), .depth(dep1), .err_under(eu_a[1]), .err_over(eo_a[1]));

  nest_block_checker #(.DEPTH_W(16), .CASE_INS(0)) u2 (
    .clk(clk), .reset(reset), .clr(clr_a[2]), .in_valid(vld_a[2]), .in(in_a[2]),
    .result(res_a[2]), .depth(dep2), .err_under(eu_a[2]), .err_over(eo_a[2]));

  task automatic chk_one(input exp_t e);
    int d_obs;
    d_obs = (e.dut == 0) ? int'(dep0) : (e.dut == 1) ? int'(dep1) : int'(dep2);
    total++;
    assert (d_obs === e.dep) else begin
      bad++; $error("FAIL %s depth: got %0d want %0d", e.tag, d_obs, e.dep);
    end
    total++;
    assert (res_a[e.dut] === e.res) else begin
      bad++; $error("FAIL %s result: got %b want %b", e.tag, res_a[e.dut], e.res);
    end
    total++;
    assert (eu_a[e.dut] === e.eu) else begin
      bad++; $error("FAIL %s err_under: got %b want %b", e.tag, eu_a[e.dut], e.eu);
    end
    total++;
    assert (eo_a[e.dut] === e.eo) else begin
      bad++; $error("FAIL %s err_over: got %b want %b", e.tag, eo_a[e.dut], e.eo);
    end
  endtask

  task automatic push_exp(input int d, input int ed, input logic er, input logic eeu,
                          input logic eeo, input string tag);
    exp_t e;
    e.dut = d; e.dep = ed; e.res = er; e.eu = eeu; e.eo = eeo; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_one(e);
    end
  endtask

  task automatic step(input int d, input logic [7:0] c, input logic v, input logic cl,
                      input logic chk, input int ed, input logic er, input logic eeu,
                      input logic eeo, input string tag);
    @(negedge clk);
    in_a[d]  = c;
    vld_a[d] = v;
    clr_a[d] = cl;
    if (chk) push_exp(d, ed, er, eeu, eeo, tag);
    @(posedge clk);
    #1;
    vld_a[d] = 1'b0;
    clr_a[d] = 1'b0;
    drain();
  endtask

  task automatic word(input int d, input string s);
    for (int i = 0; i < s.len(); i++) step(d, s[i], 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, "");
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vld_a[d] = 1'b0;
      push_exp(d, 0, 1'b1, 1'b0, 1'b0, tag);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    string s;
    int    ed [10];
    logic  er [10];
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      clr_a[d] = 1'b0; vld_a[d] = 1'b0; in_a[d] = 8'h00;
    end
    repeat (2) @(posedge clk);
    do_reset("reset_state");

    // "begin end " on the default instance
    word(0, "begi");
    step(0, "n", 1, 0, 1, 1, 0, 0, 0, "begin_n");
    step(0, " ", 1, 0, 1, 1, 0, 0, 0, "begin_sp");
    word(0, "en");
    step(0, "d", 1, 0, 1, 0, 1, 0, 0, "end_d");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "end_sp");

    // "begins " reverts the tentative increment
    word(0, "begi");
    step(0, "n", 1, 0, 1, 1, 0, 0, 0, "begins_n");
    step(0, "s", 1, 0, 1, 0, 1, 0, 0, "begins_s");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "begins_sp");

    // underflow then lock then soft clear
    do_reset("reset_2");
    word(0, "en");
    step(0, "d", 1, 0, 1, 0, 0, 0, 0, "under_pend");
    step(0, " ", 1, 0, 1, 0, 0, 1, 0, "under_commit");
    word(0, "begin");
    step(0, " ", 1, 0, 1, 0, 0, 1, 0, "under_lock");
    step(0, 8'h00, 0, 1, 1, 0, 1, 0, 0, "under_clr");

    // case handling
    word(0, "BEGIN begin");
    step(0, " ", 1, 0, 1, 2, 0, 0, 0, "case_ins");
    word(2, "BEGIN begin");
    step(2, " ", 1, 0, 1, 1, 0, 0, 0, "case_sens");

    // overflow on the 2-bit instance
    for (int i = 0; i < 3; i++) begin
      word(1, "begin");
      step(1, " ", 1, 0, 1, i + 1, 0, 0, 0, "over_fill");
    end
    word(1, "begi");
    step(1, "n", 1, 0, 1, 3, 0, 0, 0, "over_pend");
    step(1, " ", 1, 0, 1, 3, 0, 0, 1, "over_commit");
    word(1, "end");
    step(1, " ", 1, 0, 1, 3, 0, 0, 1, "over_lock");
    step(1, 8'h00, 0, 1, 1, 0, 1, 0, 0, "over_clr");

    // prefixes and suffixes never count
    do_reset("reset_3");
    word(0, "xbegin");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "xbegin");
    word(0, "en");
    step(0, "d", 1, 0, 1, 0, 0, 0, 0, "ends_pend");
    step(0, "s", 1, 0, 1, 0, 1, 0, 0, "ends_s");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "ends_sp");
    word(0, "begin");
    step(0, "1", 1, 0, 1, 0, 1, 0, 0, "begin1");
    step(0, 8'h0D, 1, 0, 1, 0, 1, 0, 0, "begin1_cr");
    word(0, "beg");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "beg");

    // valid gaps between every character
    s  = "begin\tend\n";
    ed = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    er = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      step(0, s[i], 1, 0, 1, ed[i], er[i], 0, 0, "gap_valid");
      step(0, "x",  0, 0, 1, ed[i], er[i], 0, 0, "gap_hold");
    end

    // reset mid-word discards the partial "beg"
    word(0, "beg");
    do_reset("reset_midword");
    word(0, "in");
    step(0, " ", 1, 0, 1, 0, 1, 0, 0, "midword_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
